// File: rtl/tdc_pkg.sv
// Shared types and constants for the TDC hit serializer: shot record layout,
// FSM states and the hit-count clamp.
package tdc_pkg;

  localparam int TDC_HIT_W    = 15;
  localparam int TDC_INT_W    = 4;
  localparam int TDC_MAX_HITS = 4;
  localparam int TDC_DEPTH    = 4;

  typedef struct packed {
    logic [2:0]                        num;
    logic [TDC_MAX_HITS*TDC_HIT_W-1:0] data;
    logic [TDC_MAX_HITS*TDC_INT_W-1:0] ints;
  } shot_rec_t;

  typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} tdc_state_e;

  // Hit counts above MAX_HITS are treated as a full record
  function automatic logic [2:0] clamp_num(input logic [2:0] num);
    return (num > 3'(TDC_MAX_HITS)) ? 3'(TDC_MAX_HITS) : num;
  endfunction

endpackage

// File: rtl/tdc_shot_fifo.sv
// Synchronous FIFO of whole shot records. A push into a full FIFO is accepted
// when a pop happens on the same edge.
module tdc_shot_fifo
  import tdc_pkg::*;
#(
  parameter int DEPTH = TDC_DEPTH
) (
  input  logic      clk,
  input  logic      rstn,
  input  logic      i_flush,
  input  logic      i_push,
  input  logic      i_pop,
  input  shot_rec_t i_rec,
  output shot_rec_t o_head,
  output logic      o_full,
  output logic      o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  shot_rec_t   r_mem [DEPTH];
  logic        w_wr;
  logic        w_rd;

  // Extra wrap bit separates full (same slot, other lap) from empty
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_rd    = i_pop & ~o_empty;
  assign w_wr    = i_push & (~o_full | w_rd);
  assign o_head  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
      if (w_rd) r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_rec;
  end

endmodule

// File: rtl/tdc_hit_serializer.sv
// Buffers per-shot TDC records and emits their hits one by one on the
// histogram stream, blanking near-field hits and counting dropped shots.
module tdc_hit_serializer
  import tdc_pkg::*;
#(
  parameter int DEPTH = TDC_DEPTH
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              en,
  input  logic [TDC_HIT_W-1:0]              gate_min,
  input  logic                              shot_valid,
  input  logic [2:0]                        shot_num,
  input  logic [TDC_MAX_HITS*TDC_HIT_W-1:0] shot_data,
  input  logic [TDC_MAX_HITS*TDC_INT_W-1:0] shot_int,
  output logic [TDC_HIT_W-1:0]              TDC_Odata,
  output logic [TDC_INT_W-1:0]              TDC_Oint,
  output logic                              TDC_Ovalid,
  input  logic                              TDC_Oready,
  output logic [15:0]                       drop_cnt,
  output logic                              busy
);

  localparam int HIT_W    = TDC_HIT_W;
  localparam int INT_W    = TDC_INT_W;
  localparam int MAX_HITS = TDC_MAX_HITS;

  tdc_state_e                  r_state;
  tdc_state_e                  w_state_nxt;
  shot_rec_t                   w_in_rec;
  shot_rec_t                   w_head;
  logic                        w_full;
  logic                        w_empty;
  logic                        w_push;
  logic                        w_pop;
  logic                        w_load;
  logic                        w_step;
  logic                        w_drop;
  logic                        w_last;
  logic                        w_blank;
  logic                        w_slot_free;
  logic [HIT_W-1:0]            w_hit;
  logic [INT_W-1:0]            w_hint;
  logic [MAX_HITS*HIT_W-1:0]   r_data;
  logic [MAX_HITS*INT_W-1:0]   r_int;
  logic [2:0]                  r_num;
  logic [1:0]                  r_k;
  logic [HIT_W-1:0]            r_odata;
  logic [INT_W-1:0]            r_oint;
  logic                        r_ovalid;
  logic [15:0]                 r_drop;

  assign w_in_rec    = '{num: clamp_num(shot_num), data: shot_data, ints: shot_int};
  assign w_push      = en & shot_valid;
  assign w_hit       = r_data[int'(r_k)*HIT_W +: HIT_W];
  assign w_hint      = r_int[int'(r_k)*INT_W +: INT_W];
  assign w_blank     = (w_hit < gate_min);
  assign w_last      = ({1'b0, r_k} == (r_num - 3'd1));
  assign w_slot_free = ~r_ovalid | TDC_Oready;

  tdc_shot_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_flush (~en),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_rec   (w_in_rec),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!en)                   w_state_nxt = S_IDLE;
    else if (w_pop)            w_state_nxt = w_load ? S_SEND : S_IDLE;
    else if (w_step && w_last) w_state_nxt = S_IDLE;
    else                       w_state_nxt = r_state;
  end

  // A step consumes hit k once the output slot is free; the last step chains the next record
  always_comb begin
    w_step = 1'b0;
    w_pop  = 1'b0;
    case (r_state)
      S_IDLE: w_pop = en & ~w_empty;
      S_SEND: begin
        w_step = en & w_slot_free;
        w_pop  = en & w_slot_free & w_last & ~w_empty;
      end
      default: begin
        w_step = 1'b0;
        w_pop  = 1'b0;
      end
    endcase
    w_load = w_pop & (w_head.num != 3'd0);
    w_drop = w_push & w_full & ~w_pop;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data   <= '0;
      r_int    <= '0;
      r_num    <= 3'd0;
      r_k      <= 2'd0;
      r_odata  <= '0;
      r_oint   <= '0;
      r_ovalid <= 1'b0;
    end else if (!en) begin
      r_ovalid <= 1'b0;
    end else begin
      if (w_load) begin
        r_data <= w_head.data;
        r_int  <= w_head.ints;
        r_num  <= w_head.num;
        r_k    <= 2'd0;
      end else if (w_step) begin
        r_k <= r_k + 2'd1;
      end
      if (w_step) begin
        r_ovalid <= ~w_blank;
        if (!w_blank) begin
          r_odata <= w_hit;
          r_oint  <= w_hint;
        end
      end else if (TDC_Oready) begin
        r_ovalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                              r_drop <= 16'd0;
    else if (w_drop && r_drop != 16'hFFFF)  r_drop <= r_drop + 16'd1;
  end

  assign TDC_Odata  = r_odata;
  assign TDC_Oint   = r_oint;
  assign TDC_Ovalid = r_ovalid;
  assign drop_cnt   = r_drop;
  assign busy       = ~w_empty | (r_state != S_IDLE) | r_ovalid;

endmodule

// File: tb/tb_tdc_hit_serializer.sv
// Directed self-checking bench for tdc_hit_serializer; inputs driven and
// outputs sampled on the falling clock edge.
module tb_tdc_hit_serializer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic [14:0] gate_min;
  logic        shot_valid;
  logic [2:0]  shot_num;
  logic [59:0] shot_data;
  logic [15:0] shot_int;
  logic [14:0] TDC_Odata;
  logic [3:0]  TDC_Oint;
  logic        TDC_Ovalid;
  logic        TDC_Oready;
  logic [15:0] drop_cnt;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tdc_hit_serializer dut (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .gate_min   (gate_min),
    .shot_valid (shot_valid),
    .shot_num   (shot_num),
    .shot_data  (shot_data),
    .shot_int   (shot_int),
    .TDC_Odata  (TDC_Odata),
    .TDC_Oint   (TDC_Oint),
    .TDC_Ovalid (TDC_Ovalid),
    .TDC_Oready (TDC_Oready),
    .drop_cnt   (drop_cnt),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [59:0] pk4(input logic [14:0] a, input logic [14:0] b,
                                      input logic [14:0] c, input logic [14:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [15:0] pki(input logic [3:0] a, input logic [3:0] b,
                                      input logic [3:0] c, input logic [3:0] d);
    return {d, c, b, a};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  // Present a record for one cycle; returns on the following falling edge
  task automatic strobe(input logic [2:0] num, input logic [59:0] d, input logic [15:0] it);
    shot_num   = num;
    shot_data  = d;
    shot_int   = it;
    shot_valid = 1'b1;
    @(negedge clk);
    shot_valid = 1'b0;
  endtask

  task automatic expect_hit(input string tag, input logic [14:0] d, input logic [3:0] it);
    check({tag, "_valid"}, 32'(TDC_Ovalid), 32'd1);
    check({tag, "_data"},  32'(TDC_Odata),  32'(d));
    check({tag, "_int"},   32'(TDC_Oint),   32'(it));
  endtask

  initial begin
    rstn       = 1'b0;
    en         = 1'b1;
    gate_min   = 15'd0;
    shot_valid = 1'b0;
    shot_num   = 3'd0;
    shot_data  = 60'd0;
    shot_int   = 16'd0;
    TDC_Oready = 1'b1;
    step();
    check("rst_valid", 32'(TDC_Ovalid), 32'd0);
    check("rst_data",  32'(TDC_Odata),  32'd0);
    check("rst_drop",  32'(drop_cnt),   32'd0);
    check("rst_busy",  32'(busy),       32'd0);
    rstn = 1'b1;
    step();

    // 1: single shot, continuous ready
    strobe(3'd3, pk4(15'd100, 15'd200, 15'd300, 15'd0), pki(4'd1, 4'd2, 4'd3, 4'd0));
    check("t1_lat_a", 32'(TDC_Ovalid), 32'd0);
    step();
    check("t1_lat_b", 32'(TDC_Ovalid), 32'd0);
    step();
    expect_hit("t1_h0", 15'd100, 4'd1);
    step();
    expect_hit("t1_h1", 15'd200, 4'd2);
    step();
    expect_hit("t1_h2", 15'd300, 4'd3);
    step();
    check("t1_end_valid", 32'(TDC_Ovalid), 32'd0);
    check("t1_end_busy",  32'(busy),       32'd0);
    step();

    // 2: backpressure on the second hit
    strobe(3'd3, pk4(15'd100, 15'd200, 15'd300, 15'd0), pki(4'd1, 4'd2, 4'd3, 4'd0));
    step();
    step();
    expect_hit("t2_h0", 15'd100, 4'd1);
    step();
    expect_hit("t2_h1", 15'd200, 4'd2);
    TDC_Oready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      expect_hit("t2_hold", 15'd200, 4'd2);
    end
    TDC_Oready = 1'b1;
    step();
    expect_hit("t2_h2", 15'd300, 4'd3);
    step();
    check("t2_end_valid", 32'(TDC_Ovalid), 32'd0);
    step();

    // 3: blanking below gate_min
    gate_min = 15'd150;
    strobe(3'd4, pk4(15'd100, 15'd200, 15'd50, 15'd400), pki(4'd1, 4'd2, 4'd3, 4'd4));
    step();
    step();
    check("t3_blank0", 32'(TDC_Ovalid), 32'd0);
    step();
    expect_hit("t3_h1", 15'd200, 4'd2);
    step();
    check("t3_blank2", 32'(TDC_Ovalid), 32'd0);
    step();
    expect_hit("t3_h3", 15'd400, 4'd4);
    step();
    check("t3_end_valid", 32'(TDC_Ovalid), 32'd0);
    check("t3_end_busy",  32'(busy),       32'd0);
    gate_min = 15'd0;
    step();

    // 4: two strobes fill the output and shift stages, then six more: four stored, two dropped
    TDC_Oready = 1'b0;
    for (int i = 0; i < 8; i++)
      strobe(3'd1, pk4(15'(10 + i), 15'd0, 15'd0, 15'd0), pki(4'(i), 4'd0, 4'd0, 4'd0));
    check("t4_drop", 32'(drop_cnt), 32'd2);
    check("t4_busy", 32'(busy),     32'd1);
    expect_hit("t4_r0", 15'd10, 4'd0);

    // 5: FIFO full, strobe on the edge that pops
    TDC_Oready = 1'b1;
    strobe(3'd1, pk4(15'd99, 15'd0, 15'd0, 15'd0), pki(4'd9, 4'd0, 4'd0, 4'd0));
    check("t5_drop_same", 32'(drop_cnt), 32'd2);
    for (int i = 1; i < 6; i++) begin
      expect_hit("t4_seq", 15'(10 + i), 4'(i));
      step();
    end
    expect_hit("t5_accepted", 15'd99, 4'd9);
    step();
    check("t5_end_valid", 32'(TDC_Ovalid), 32'd0);
    check("t5_drop_final", 32'(drop_cnt),  32'd2);
    strobe(3'd0, pk4(15'd77, 15'd77, 15'd77, 15'd77), pki(4'd7, 4'd7, 4'd7, 4'd7));
    check("t5_num0_busy",  32'(busy),       32'd1);
    check("t5_num0_valid", 32'(TDC_Ovalid), 32'd0);
    step();
    check("t5_num0_busy2",  32'(busy),       32'd0);
    check("t5_num0_valid2", 32'(TDC_Ovalid), 32'd0);
    step();
    check("t5_num0_valid3", 32'(TDC_Ovalid), 32'd0);

    // 6: en low mid-record, strobe ignored while disabled, then async reset mid-send
    TDC_Oready = 1'b0;
    strobe(3'd2, pk4(15'd500, 15'd600, 15'd0, 15'd0), pki(4'd5, 4'd6, 4'd0, 4'd0));
    step();
    step();
    expect_hit("t6_h0", 15'd500, 4'd5);
    en = 1'b0;
    step();
    check("t6_en_valid", 32'(TDC_Ovalid), 32'd0);
    check("t6_en_busy",  32'(busy),       32'd0);
    check("t6_en_drop",  32'(drop_cnt),   32'd2);
    strobe(3'd1, pk4(15'd1, 15'd0, 15'd0, 15'd0), pki(4'd1, 4'd0, 4'd0, 4'd0));
    check("t6_dis_busy", 32'(busy),     32'd0);
    check("t6_dis_drop", 32'(drop_cnt), 32'd2);
    en = 1'b1;
    step();
    strobe(3'd2, pk4(15'd500, 15'd600, 15'd0, 15'd0), pki(4'd5, 4'd6, 4'd0, 4'd0));
    step();
    step();
    expect_hit("t6_h0b", 15'd500, 4'd5);
    #2 rstn = 1'b0;
    #1;
    check("t6_rst_valid", 32'(TDC_Ovalid), 32'd0);
    check("t6_rst_data",  32'(TDC_Odata),  32'd0);
    check("t6_rst_int",   32'(TDC_Oint),   32'd0);
    check("t6_rst_drop",  32'(drop_cnt),   32'd0);
    check("t6_rst_busy",  32'(busy),       32'd0);
    step();
    rstn       = 1'b1;
    TDC_Oready = 1'b1;
    step();
    strobe(3'd1, pk4(15'd42, 15'd0, 15'd0, 15'd0), pki(4'd3, 4'd0, 4'd0, 4'd0));
    step();
    step();
    expect_hit("t6_post_rst", 15'd42, 4'd3);
    step();
    check("t6_post_end", 32'(TDC_Ovalid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
